// File: rtl/tx_ordered_set_ctrl.sv
// Transmit ordered-set controller: wraps MAC frames in /S/ ... /T/ /R/ [/R/] and fills
// the gaps with /I1/ or /I2/ idle pairs so that every K28.5 lands in an even slot.
module tx_ordered_set_ctrl (
  input  logic        sync_clk,
  input  logic        mr_main_reset,
  input  logic        tx_en,
  input  logic        tx_er,
  input  logic [7:0]  txd,
  input  logic        rd_pos,
  output logic [7:0]  tx_byte,
  output logic        tx_is_k,
  output logic        tx_even,
  output logic        tx_busy,
  output logic [15:0] pkt_count,
  output logic [7:0]  err_count
);

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;
  localparam logic [7:0] OS_S  = 8'hFB;
  localparam logic [7:0] OS_T  = 8'hFD;
  localparam logic [7:0] OS_R  = 8'hF7;
  localparam logic [7:0] OS_V  = 8'hFE;

  typedef enum logic [2:0] {
    IDLE_K,
    IDLE_D,
    SOP,
    DATA,
    EOP_T,
    EOP_R,
    EOP_R2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        tx_is_k_q, tx_is_k_d;
  logic        tx_even_q;
  logic [15:0] pkt_q, pkt_d;
  logic [7:0]  err_q, err_d;

  always_ff @(posedge sync_clk or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      state_q   <= IDLE_K;
      tx_byte_q <= K28_5;
      tx_is_k_q <= 1'b1;
      tx_even_q <= 1'b1;
      pkt_q     <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      tx_byte_q <= tx_byte_d;
      tx_is_k_q <= tx_is_k_d;
      tx_even_q <= ~tx_even_q;
      pkt_q     <= pkt_d;
      err_q     <= err_d;
    end
  end

  // The registered byte/k always belong to the state being entered, so the
  // emission is decoded from state_d rather than state_q.
  always_comb begin
    state_d   = state_q;
    tx_byte_d = K28_5;
    tx_is_k_d = 1'b1;
    pkt_d     = pkt_q;
    err_d     = err_q;

    case (state_q)
      IDLE_K:    state_d = IDLE_D;
      IDLE_D:    state_d = tx_en ? SOP : IDLE_K;
      SOP, DATA: state_d = tx_en ? DATA : EOP_T;
      EOP_T:     state_d = EOP_R;
      EOP_R:     state_d = tx_even_q ? EOP_R2 : IDLE_K;
      EOP_R2:    state_d = IDLE_K;
      default:   state_d = IDLE_K;
    endcase

    case (state_d)
      IDLE_K: begin
        tx_byte_d = K28_5;
        tx_is_k_d = 1'b1;
      end
      IDLE_D: begin
        tx_byte_d = rd_pos ? D5_6 : D16_2;
        tx_is_k_d = 1'b0;
      end
      SOP: begin
        tx_byte_d = OS_S;
        tx_is_k_d = 1'b1;
      end
      DATA: begin
        if (tx_er) begin
          tx_byte_d = OS_V;
          tx_is_k_d = 1'b1;
          err_d     = (err_q != '1) ? err_q + 8'd1 : err_q;
        end else begin
          tx_byte_d = txd;
          tx_is_k_d = 1'b0;
        end
      end
      EOP_T: begin
        tx_byte_d = OS_T;
        tx_is_k_d = 1'b1;
        pkt_d     = (pkt_q != '1) ? pkt_q + 16'd1 : pkt_q;
      end
      EOP_R, EOP_R2: begin
        tx_byte_d = OS_R;
        tx_is_k_d = 1'b1;
      end
      default: begin
        tx_byte_d = K28_5;
        tx_is_k_d = 1'b1;
      end
    endcase
  end

  assign tx_byte   = tx_byte_q;
  assign tx_is_k   = tx_is_k_q;
  assign tx_even   = tx_even_q;
  assign tx_busy   = (state_q != IDLE_K) && (state_q != IDLE_D);
  assign pkt_count = pkt_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_tx_ordered_set_ctrl.sv
// Bench for tx_ordered_set_ctrl: directed frames plus randomized traffic checked
// cycle by cycle against a slot-level model of the ordered-set stream.
module tb_tx_ordered_set_ctrl;

  logic        sync_clk = 1'b0;
  logic        mr_main_reset = 1'b1;
  logic        tx_en = 1'b0;
  logic        tx_er = 1'b0;
  logic [7:0]  txd = 8'h00;
  logic        rd_pos = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_is_k;
  logic        tx_even;
  logic        tx_busy;
  logic [15:0] pkt_count;
  logic [7:0]  err_count;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  // Slot-level model: parity of the current slot, whether it is an odd idle slot,
  // whether a frame is open, and the queue of /R/ codes still owed after /T/.
  bit          m_even, m_idle_odd, m_in_frame;
  logic [7:0]  m_tail [$];
  int          m_pkt, m_err;
  logic [10:0] exp_out;

  logic [7:0]  pat [6];
  logic [7:0]  cap [16];
  logic [7:0]  want [10];

  tx_ordered_set_ctrl dut (
    .sync_clk      (sync_clk),
    .mr_main_reset (mr_main_reset),
    .tx_en         (tx_en),
    .tx_er         (tx_er),
    .txd           (txd),
    .rd_pos        (rd_pos),
    .tx_byte       (tx_byte),
    .tx_is_k       (tx_is_k),
    .tx_even       (tx_even),
    .tx_busy       (tx_busy),
    .pkt_count     (pkt_count),
    .err_count     (err_count)
  );

  always #5 sync_clk = ~sync_clk;

  function automatic void model_reset();
    m_even     = 1'b1;
    m_idle_odd = 1'b0;
    m_in_frame = 1'b0;
    m_tail.delete();
    m_pkt      = 0;
    m_err      = 0;
    exp_out    = {8'hBC, 1'b1, 1'b1, 1'b0};
  endfunction

  function automatic void model_slot(input logic en, input logic er, input logic [7:0] d, input logic rd);
    bit         se, idle, ok;
    logic [7:0] ob;
    se   = !m_even;
    idle = 1'b0;
    if (m_tail.size() > 0) begin
      ob = m_tail.pop_front();
      ok = 1'b1;
    end else if (m_in_frame) begin
      if (en) begin
        ob = er ? 8'hFE : d;
        ok = er;
        if (er && m_err < 255) m_err++;
      end else begin
        m_in_frame = 1'b0;
        ob = 8'hFD;
        ok = 1'b1;
        if (m_pkt < 65535) m_pkt++;
        m_tail.push_back(8'hF7);
        if (!se) m_tail.push_back(8'hF7);
      end
    end else if (m_idle_odd && en) begin
      ob = 8'hFB;
      ok = 1'b1;
      m_in_frame = 1'b1;
    end else begin
      idle = 1'b1;
      ob   = se ? 8'hBC : (rd ? 8'hC5 : 8'h50);
      ok   = se;
    end
    m_idle_odd = idle && !se;
    m_even     = se;
    exp_out    = {ob, ok, se, !idle};
  endfunction

  task automatic step(input logic en, input logic er, input logic [7:0] d, input logic rd);
    @(negedge sync_clk);
    tx_en  = en;
    tx_er  = er;
    txd    = d;
    rd_pos = rd;
    model_slot(en, er, d, rd);
    @(posedge sync_clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge sync_clk);
    tx_en = 1'b0; tx_er = 1'b0; txd = 8'h00; rd_pos = 1'b0;
    mr_main_reset = 1'b1;
    @(posedge sync_clk);
    #1 mr_main_reset = 1'b0;
    model_reset();
  endtask

  task automatic align_odd_idle();
    for (int i = 0; i < 8 && !m_idle_odd; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    @(negedge sync_clk);
    #2 mr_main_reset = 1'b1;
    #1;
    n_checks++;
    if ({tx_byte, tx_is_k, tx_even, tx_busy, pkt_count, err_count} !== {8'hBC, 3'b110, 16'h0000, 8'h00}) begin
      n_fails++;
      $display("FAIL reset_state got %h want %h", {tx_byte, tx_is_k, tx_even, tx_busy, pkt_count, err_count},
               {8'hBC, 3'b110, 16'h0000, 8'h00});
    end
    @(posedge sync_clk);
    #1 mr_main_reset = 1'b0;
    model_reset();
  endtask

  task automatic test_idle();
    logic r;
    for (int i = 0; i < 16; i++) begin
      r = (i < 8) ? 1'b0 : 1'($urandom);
      step(1'b0, 1'($urandom), 8'($urandom), r);
      n_checks++;
      if ({tx_byte, tx_is_k, tx_even, tx_busy} !== exp_out || pkt_count !== m_pkt[15:0] || err_count !== m_err[7:0]) begin
        n_fails++;
        $display("FAIL idle cyc %0d got %h pkt %0d err %0d want %h", i, {tx_byte, tx_is_k, tx_even, tx_busy},
                 pkt_count, err_count, exp_out);
      end
      if (i < 8) begin
        n_checks++;
        if ({tx_byte, tx_is_k, tx_even} !== ((i % 2 == 0) ? {8'h50, 2'b00} : {8'hBC, 2'b11})) begin
          n_fails++;
          $display("FAIL idle_pattern cyc %0d got %h want %h", i, {tx_byte, tx_is_k, tx_even},
                   (i % 2 == 0) ? {8'h50, 2'b00} : {8'hBC, 2'b11});
        end
      end
    end
  endtask

  task automatic test_frames();
    int n;
    for (int f = 0; f < 3; f++) begin
      n = (f == 1) ? 5 : 6;
      do_reset();
      align_odd_idle();
      for (int c = 0; c < n + 4; c++) begin
        step(c < n, (f == 2) && (c == 3), (c < n) ? pat[c] : 8'h00, 1'b0);
        cap[c] = tx_byte;
        n_checks++;
        if ({tx_byte, tx_is_k, tx_even, tx_busy} !== exp_out || pkt_count !== m_pkt[15:0] || err_count !== m_err[7:0]) begin
          n_fails++;
          $display("FAIL frame%0d cyc %0d got %h pkt %0d err %0d want %h", f, c, {tx_byte, tx_is_k, tx_even, tx_busy},
                   pkt_count, err_count, exp_out);
        end
      end
      if (f == 0) want = '{8'hFB, 8'h55, 8'hD5, 8'h01, 8'h02, 8'h03, 8'hFD, 8'hF7, 8'hBC, 8'h50};
      if (f == 1) want = '{8'hFB, 8'h55, 8'hD5, 8'h01, 8'h02, 8'hFD, 8'hF7, 8'hF7, 8'hBC, 8'h00};
      if (f == 2) want = '{8'hFB, 8'h55, 8'hD5, 8'hFE, 8'h02, 8'h03, 8'hFD, 8'hF7, 8'hBC, 8'h50};
      for (int c = 0; c < n + 4; c++) begin
        n_checks++;
        if (cap[c] !== want[c]) begin
          n_fails++;
          $display("FAIL frame%0d_seq slot %0d got %h want %h", f, c, cap[c], want[c]);
        end
      end
      n_checks++;
      if (pkt_count !== 16'd1 || err_count !== ((f == 2) ? 8'd1 : 8'd0)) begin
        n_fails++;
        $display("FAIL frame%0d_counts got pkt %0d err %0d want pkt 1 err %0d", f, pkt_count, err_count, (f == 2) ? 1 : 0);
      end
    end
  endtask

  task automatic test_back_to_back();
    int run = 0;
    bit en  = 1'b0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (run == 0) begin
        en  = !en;
        run = en ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 3));
      end
      run--;
      step(en, ($urandom_range(0, 9) == 0), 8'($urandom), 1'($urandom));
      n_checks++;
      if ({tx_byte, tx_is_k, tx_even, tx_busy} !== exp_out || pkt_count !== m_pkt[15:0] || err_count !== m_err[7:0]) begin
        n_fails++;
        $display("FAIL back_to_back cyc %0d got %h pkt %0d err %0d want %h pkt %0d err %0d", i,
                 {tx_byte, tx_is_k, tx_even, tx_busy}, pkt_count, err_count, exp_out, m_pkt, m_err);
      end
    end
  endtask

  task automatic test_random();
    bit en = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 4) == 0) en = !en;
      step(en, ($urandom_range(0, 11) == 0), 8'($urandom), 1'($urandom));
      n_checks++;
      if ({tx_byte, tx_is_k, tx_even, tx_busy} !== exp_out || pkt_count !== m_pkt[15:0] || err_count !== m_err[7:0]) begin
        n_fails++;
        $display("FAIL random cyc %0d got %h pkt %0d err %0d want %h pkt %0d err %0d", i,
                 {tx_byte, tx_is_k, tx_even, tx_busy}, pkt_count, err_count, exp_out, m_pkt, m_err);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    align_odd_idle();
    for (int c = 0; c < 4; c++) step(1'b1, 1'b0, pat[c], 1'b0);
    #2 mr_main_reset = 1'b1;
    #1;
    n_checks++;
    if ({tx_byte, tx_is_k, tx_even, tx_busy, pkt_count, err_count} !== {8'hBC, 3'b110, 16'h0000, 8'h00}) begin
      n_fails++;
      $display("FAIL midframe_reset got %h want %h", {tx_byte, tx_is_k, tx_even, tx_busy, pkt_count, err_count},
               {8'hBC, 3'b110, 16'h0000, 8'h00});
    end
    @(posedge sync_clk);
    #1;
    n_checks++;
    if ({tx_byte, tx_is_k, tx_even, tx_busy, pkt_count, err_count} !== {8'hBC, 3'b110, 16'h0000, 8'h00}) begin
      n_fails++;
      $display("FAIL midframe_reset_held got %h want %h", {tx_byte, tx_is_k, tx_even, tx_busy, pkt_count, err_count},
               {8'hBC, 3'b110, 16'h0000, 8'h00});
    end
    mr_main_reset = 1'b0;
    model_reset();
    align_odd_idle();
    for (int c = 0; c < 10; c++) begin
      step(c < 6, 1'b0, (c < 6) ? pat[c] : 8'h00, 1'b1);
      n_checks++;
      if ({tx_byte, tx_is_k, tx_even, tx_busy} !== exp_out || pkt_count !== m_pkt[15:0] || err_count !== m_err[7:0]) begin
        n_fails++;
        $display("FAIL after_reset cyc %0d got %h pkt %0d err %0d want %h", c, {tx_byte, tx_is_k, tx_even, tx_busy},
                 pkt_count, err_count, exp_out);
      end
    end
    n_checks++;
    if (pkt_count !== 16'd1) begin
      n_fails++;
      $display("FAIL after_reset_pkt got %0d want 1", pkt_count);
    end
  endtask

  task automatic test_err_saturation();
    do_reset();
    align_odd_idle();
    for (int c = 0; c < 274; c++) begin
      step(c < 270, 1'b1, 8'($urandom), 1'b0);
      n_checks++;
      if ({tx_byte, tx_is_k, tx_even, tx_busy} !== exp_out || pkt_count !== m_pkt[15:0] || err_count !== m_err[7:0]) begin
        n_fails++;
        $display("FAIL err_sat cyc %0d got %h pkt %0d err %0d want %h err %0d", c, {tx_byte, tx_is_k, tx_even, tx_busy},
                 pkt_count, err_count, exp_out, m_err);
      end
    end
    n_checks++;
    if (err_count !== 8'hFF || pkt_count !== 16'd1) begin
      n_fails++;
      $display("FAIL err_sat_final got err %h pkt %0d want err ff pkt 1", err_count, pkt_count);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    pat = '{8'h55, 8'h55, 8'hD5, 8'h01, 8'h02, 8'h03};
    model_reset();
    test_reset();
    test_idle();
    test_frames();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    test_err_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/tx_ordered_set_ctrl.md
TX_ORDERED_SET_CTRL -- requirements
Module: tx_ordered_set_ctrl

Interface
REQ-001 SHALL have: sync_clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have: mr_main_reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have: tx_en  input  1  frame-valid from MAC side, sampled each sync_clk.
REQ-004 SHALL have: tx_er  input  1  error flag, sampled with tx_en.
REQ-005 SHALL have: txd  input  8  frame byte, sampled with tx_en.
REQ-006 SHALL have: rd_pos  input  1  current running disparity from the downstream 8b/10b encoder, 1 = positive.
REQ-007 SHALL have: tx_byte  output  8  octet to encode, registered.
REQ-008 SHALL have: tx_is_k  output  1  tx_byte is a K code, registered.
REQ-009 SHALL have: tx_even  output  1  current output slot is even, registered.
REQ-010 SHALL have: tx_busy  output  1  state is not IDLE_K/IDLE_D.
REQ-011 SHALL have: pkt_count  output  16  frames terminated with /T/, saturating.
REQ-012 SHALL have: err_count  output  8  /V/ codes emitted, saturating.

Function
REQ-013 SHALL hold code constants: K28.5=8'hBC, D5.6=8'hC5, D16.2=8'h50, /S/=8'hFB, /T/=8'hFD, /R/=8'hF7, /V/=8'hFE.
REQ-014 SHALL update outputs from inputs sampled on the previous edge, giving 1-cycle latency from txd to tx_byte.
REQ-015 SHALL toggle tx_even every cycle, free-running, independent of state.
REQ-016 SHALL implement states IDLE_K, IDLE_D, SOP, DATA, EOP_T, EOP_R, EOP_R2.
REQ-017 IDLE_K SHALL emit K28.5 with tx_is_k=1 and occur only in even slots.
REQ-017a IDLE_K SHALL always go to IDLE_D.
REQ-018 IDLE_D SHALL emit D5.6 (I1) when rd_pos=1, else D16.2 (I2), with tx_is_k=0, in odd slots only.
REQ-019 IDLE_D SHALL go to SOP if tx_en=1 sampled, else to IDLE_K.
REQ-019a A tx_en=1 byte sampled during IDLE_K SHALL be discarded as preamble.
REQ-020 SOP SHALL emit /S/ (k=1) in an even slot, replacing the sampled txd byte.
REQ-020a SOP SHALL go to DATA if tx_en=1, else to EOP_T.
REQ-021 DATA SHALL emit the sampled txd (k=0), or /V/ (k=1) if tx_er=1.
REQ-021a DATA SHALL stay while tx_en=1 and go to EOP_T when tx_en=0.
REQ-022 EOP_T SHALL emit /T/ (k=1) and increment pkt_count, then go to EOP_R.
REQ-023 EOP_R SHALL emit /R/ (k=1).
REQ-023a EOP_R SHALL go to IDLE_K if the next slot is even, else to EOP_R2.
REQ-024 EOP_R2 SHALL emit /R/ (k=1) in an odd slot, then go to IDLE_K, so that K28.5 always lands even.
REQ-025 SHALL ignore tx_en rising during EOP_T/EOP_R/EOP_R2; such bytes are dropped and the next frame starts only via IDLE_D.
REQ-026 SHALL increment err_count on each /V/ emission.
REQ-027 SHALL saturate pkt_count at 16'hFFFF and err_count at 8'hFF with no wrap.
REQ-028 SHALL assert tx_busy in SOP, DATA, EOP_T, EOP_R and EOP_R2, and deassert it in IDLE_K and IDLE_D.

Reset
REQ-029 mr_main_reset=1 SHALL immediately force: state=IDLE_K, tx_byte=8'hBC, tx_is_k=1, tx_even=1, tx_busy=0, pkt_count=0, err_count=0.
REQ-030 Reset mid-frame SHALL abandon the frame with no /T/ and no pkt_count increment.
REQ-030a After reset release, the first edge SHALL output IDLE_D (odd).

Verification
REQ-031 Reset release, tx_en=0, rd_pos=0 for 8 cycles -> tx_byte alternates BC/50, tx_is_k alternates 1/0, tx_even alternates 1/0.
REQ-032 Idle with rd_pos=1 -> odd slots carry C5 instead of 50.
REQ-033 tx_en=1 for 6 bytes 55,55,D5,01,02,03 starting in an odd output slot -> outputs FB,55,D5,01,02,03,FD,F7, then BC on even; pkt_count=1.
REQ-034 Same frame of 5 bytes -> /T/ lands odd -> FD,F7,F7 then BC even; pkt_count=1.
REQ-035 tx_er=1 on third data byte -> that slot shows FE with k=1; err_count=1; frame still ends with /T/.
REQ-036 Assert mr_main_reset during DATA -> outputs immediately BC/k=1/tx_even=1, counters 0, tx_busy=0; next frame transmits normally.
